prog_loader: RTL

//  Hardware boot loader: pulls a length-prefixed program image from a byte-stream source (Uart receive side)
//  and assembles little-endian words from it. Writes each word to a Memory-style write port at

---
 rtl/prog_loader_if.sv | 34 +++
 rtl/prog_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream source side and word write port of the boot loader.
// The loader is the master of both request/ready pairs; the host side is the slave.
interface prog_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  src_valid;
    logic                  src_ready;
    logic [7:0]            src_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_valid;
    logic                  mem_ready;

    modport master (
        output src_valid,
        input  src_ready,
        input  src_data,
        output mem_addr,
        output mem_data,
        output mem_valid,
        input  mem_ready
    );

    modport slave (
        input  src_valid,
        output src_ready,
        output src_data,
        input  mem_addr,
        input  mem_data,
        input  mem_valid,
        output mem_ready
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: boot loader that reads a little-endian word-count header and then
// that many little-endian words from a byte source, writing each word to memory
// at BASE_ADDR + n*ADDR_STEP. The core/memory/uart are held in reset until done.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing 8-bit sum byte
// that must match the modular sum of all payload bytes.
module prog_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(4),
    parameter int                    LEN_BYTES  = 4,
    parameter int                    MAX_WORDS  = 16384
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.master bus,
    output logic          load_completed,
    output logic          hold_reset,
    output logic          error,
    output logic [31:0]   words_loaded
);

    localparam int          WB       = DATA_WIDTH / 8;
    localparam logic [15:0] LAST_WB  = 16'(WB - 1);
    localparam logic [15:0] LAST_LEN = 16'(LEN_BYTES - 1);
    localparam logic [31:0] MAX_W    = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // State reached once the last word is accepted (or for an empty image).
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = S_CHECK;
`else
    localparam state_t END_STATE = S_DONE;
`endif

    state_t                state_reg, state_next;
    logic [15:0]           byte_cnt_reg, byte_cnt_next;
    logic [31:0]           words_loaded_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic                  src_valid_reg, src_valid_next;
    logic                  mem_valid_reg, mem_valid_next;
    logic                  load_completed_reg, load_completed_next;
    logic                  error_reg, error_next;
    logic                  byte_take;
    logic                  word_take;
    logic                  checksum_ok;
    logic [31:0]           count_w;
    logic [31:0]           count_hdr;
    logic [DATA_WIDTH-1:0] word_w;

    // A transfer only happens when our own request is up in that cycle.
    assign byte_take = src_valid_reg & bus.src_ready;
    assign word_take = mem_valid_reg & bus.mem_ready;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum_reg;

    // Running modular sum of payload bytes; the header is not included.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_reg <= '0;
        end else if (state_reg == S_DATA && byte_take) begin
            sum_reg <= sum_reg + bus.src_data;
        end
    end

    assign checksum_ok = (bus.src_data == sum_reg);
`else
    assign checksum_ok = 1'b1;
`endif

    // Header byte lanes: byte k of the header lands in count[8k+:8].
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_count_lane
            if (gi < LEN_BYTES) begin : g_used
                logic [7:0] lane_reg;

                // Capture header byte gi when it arrives.
                always_ff @(posedge clk) begin
                    if (!reset) begin
                        lane_reg <= '0;
                    end else if (state_reg == S_LEN && byte_take && byte_cnt_reg == 16'(gi)) begin
                        lane_reg <= bus.src_data;
                    end
                end

                assign count_w[8*gi +: 8] = lane_reg;
            end else begin : g_unused
                assign count_w[8*gi +: 8] = 8'h00;
            end
        end
    endgenerate

    // Payload byte lanes: byte k of a word lands in word[8k+:8], LSB first.
    generate
        for (gi = 0; gi < WB; gi++) begin : g_word_lane
            logic [7:0] lane_reg;

            // Capture payload byte gi of the current word.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    lane_reg <= '0;
                end else if (state_reg == S_DATA && byte_take && byte_cnt_reg == 16'(gi)) begin
                    lane_reg <= bus.src_data;
                end
            end

            assign word_w[8*gi +: 8] = lane_reg;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_LEN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and the request/status values for the coming cycle.
    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        // The final header byte is still on the bus when the length is judged.
        count_hdr     = count_w;
        count_hdr[8*(LEN_BYTES-1) +: 8] = bus.src_data;

        case (state_reg)
            S_LEN: begin
                if (byte_take) begin
                    if (byte_cnt_reg == LAST_LEN) begin
                        byte_cnt_next = '0;
                        if (count_hdr == 32'd0) begin
                            state_next = END_STATE;
                        end else if (count_hdr > MAX_W) begin
                            state_next = S_ERROR;
                        end else begin
                            state_next = S_DATA;
                        end
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 16'd1;
                    end
                end
            end
            S_DATA: begin
                if (byte_take) begin
                    if (byte_cnt_reg == LAST_WB) begin
                        byte_cnt_next = '0;
                        state_next    = S_WRITE;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 16'd1;
                    end
                end
            end
            S_WRITE: begin
                if (word_take) begin
                    if (words_loaded_reg + 32'd1 == count_w) begin
                        state_next = END_STATE;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_CHECK: begin
                if (byte_take) begin
                    state_next = checksum_ok ? S_DONE : S_ERROR;
                end
            end
            S_DONE:  state_next = S_DONE;
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_ERROR;
        endcase

        src_valid_next      = (state_next == S_LEN) || (state_next == S_DATA) ||
                              (state_next == S_CHECK);
        mem_valid_next      = (state_next == S_WRITE);
        load_completed_next = (state_next == S_DONE);
        error_next          = (state_next == S_ERROR);
    end

    // Registered requests/status, byte counter, word counter and write address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_cnt_reg       <= '0;
            words_loaded_reg   <= '0;
            addr_reg           <= BASE_ADDR;
            mem_addr_reg       <= '0;
            src_valid_reg      <= 1'b0;
            mem_valid_reg      <= 1'b0;
            load_completed_reg <= 1'b0;
            error_reg          <= 1'b0;
        end else begin
            byte_cnt_reg       <= byte_cnt_next;
            src_valid_reg      <= src_valid_next;
            mem_valid_reg      <= mem_valid_next;
            load_completed_reg <= load_completed_next;
            error_reg          <= error_next;
            // Address is frozen for the whole write so a stalled write stays stable.
            if (state_reg == S_DATA && state_next == S_WRITE) begin
                mem_addr_reg <= addr_reg;
            end
            if (word_take) begin
                words_loaded_reg <= words_loaded_reg + 32'd1;
                addr_reg         <= addr_reg + ADDR_STEP;
            end
        end
    end

    assign bus.src_valid  = src_valid_reg;
    assign bus.mem_valid  = mem_valid_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_data   = word_w;
    assign load_completed = load_completed_reg;
    assign hold_reset     = ~load_completed_reg;
    assign error          = error_reg;
    assign words_loaded   = words_loaded_reg;

endmodule
